// File: rtl/fetch_redirect_unit.sv
// Fetch stage and PC-redirect logic for the 3-stage RV32 pipeline.
// Owns the fetch PC, the FETCH->EX pipeline register and redirect target arithmetic.
module fetch_redirect_unit #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall_FETCH,
  input  logic [1:0]        pcsrc_EX,
  input  logic [31:0]       rs1_data_EX,
  input  logic [11:0]       imm_i_EX,
  input  logic [31:0]       imm_j_extended,
  input  logic [31:0]       imm_b_extended,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc_F,
  output logic [31:0]       instr_EX,
  output logic [31:0]       pc_EX,
  output logic [31:0]       pc_plus4_EX,
  output logic              stall_EX,
  output logic              misalign,
  output logic [31:0]       redirect_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_ex_q, pc_ex_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        stall_ex_q, stall_ex_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4_f;
  logic [31:0] target;
  logic        redir;
  logic        unused_target_bit0;

  assign pc_plus4_f = pc_q + 32'd4;

  // A bubble in EX carries no real control flow, so its request is ignored.
  assign redir = stall_FETCH & ~stall_ex_q;

  always_comb begin
    target = pc_plus4_f;
    unique case (pcsrc_EX)
      2'b01:   target = (rs1_data_EX + {{20{imm_i_EX[11]}}, imm_i_EX}) & ~32'd1;
      2'b10:   target = pc_ex_q + imm_j_extended;
      2'b11:   target = pc_ex_q + imm_b_extended;
      default: target = pc_plus4_f;
    endcase
  end

  assign unused_target_bit0 = target[0];

  always_comb begin
    pc_d       = pc_plus4_f;
    instr_d    = imem_rdata;
    pc_ex_d    = pc_q;
    pc_plus4_d = pc_plus4_f;
    stall_ex_d = 1'b0;
    misalign_d = misalign_q;
    count_d    = count_q;
    if (redir) begin
      pc_d       = {target[31:2], 2'b00};
      instr_d    = NOP_INSTR;
      stall_ex_d = 1'b1;
      misalign_d = misalign_q | target[1];
      count_d    = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_ex_q    <= 32'd0;
      pc_plus4_q <= 32'd4;
      stall_ex_q <= 1'b1;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else if (en) begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_ex_q    <= pc_ex_d;
      pc_plus4_q <= pc_plus4_d;
      stall_ex_q <= stall_ex_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr      = pc_q[ADDR_W+1:2];
  assign pc_F           = pc_q;
  assign instr_EX       = instr_q;
  assign pc_EX          = pc_ex_q;
  assign pc_plus4_EX    = pc_plus4_q;
  assign stall_EX       = stall_ex_q;
  assign misalign       = misalign_q;
  assign redirect_count = count_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed self-checking bench for fetch_redirect_unit; imem returns each word's byte address.
module tb_fetch_redirect_unit;

  localparam int unsigned ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              stall_FETCH;
  logic [1:0]        pcsrc_EX;
  logic [31:0]       rs1_data_EX;
  logic [11:0]       imm_i_EX;
  logic [31:0]       imm_j_extended;
  logic [31:0]       imm_b_extended;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       pc_F;
  logic [31:0]       instr_EX;
  logic [31:0]       pc_EX;
  logic [31:0]       pc_plus4_EX;
  logic              stall_EX;
  logic              misalign;
  logic [31:0]       redirect_count;

  int checks = 0;
  int errors = 0;

  fetch_redirect_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .stall_FETCH   (stall_FETCH),
    .pcsrc_EX      (pcsrc_EX),
    .rs1_data_EX   (rs1_data_EX),
    .imm_i_EX      (imm_i_EX),
    .imm_j_extended(imm_j_extended),
    .imm_b_extended(imm_b_extended),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc_F          (pc_F),
    .instr_EX      (instr_EX),
    .pc_EX         (pc_EX),
    .pc_plus4_EX   (pc_plus4_EX),
    .stall_EX      (stall_EX),
    .misalign      (misalign),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = {18'd0, imem_addr, 2'b00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pc_ex, input logic e_stall,
                            input logic [31:0] e_cnt);
    check({tag, ".pc_F"}, pc_F, e_pc);
    check({tag, ".instr_EX"}, instr_EX, e_instr);
    check({tag, ".pc_EX"}, pc_EX, e_pc_ex);
    check({tag, ".stall_EX"}, {31'd0, stall_EX}, {31'd0, e_stall});
    check({tag, ".count"}, redirect_count, e_cnt);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; stall_FETCH = 1'b0; pcsrc_EX = 2'b00;
    rs1_data_EX = '0; imm_i_EX = '0; imm_j_extended = '0; imm_b_extended = '0;
    step();
    check_regs("reset", 32'h0, 32'h13, 32'h0, 1'b1, 32'd0);
    check("reset.pc_plus4", pc_plus4_EX, 32'd4);
    check("reset.misalign", {31'd0, misalign}, 32'd0);

    // Sequential fetch
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check_regs($sformatf("seq%0d", i), 32'(4 * i), 32'(4 * (i - 1)), 32'(4 * (i - 1)), 1'b0,
                 32'd0);
      check($sformatf("seq%0d.imem_addr", i), {20'd0, imem_addr}, 32'(i));
    end

    // JAL at pc_EX=0x10
    stall_FETCH = 1'b1; pcsrc_EX = 2'b10; imm_j_extended = 32'h20;
    step();
    check_regs("jal", 32'h30, 32'h13, 32'h14, 1'b1, 32'd1);
    check("jal.pc_plus4", pc_plus4_EX, 32'h18);
    stall_FETCH = 1'b0; pcsrc_EX = 2'b00;
    step();
    check_regs("jal_tgt", 32'h34, 32'h30, 32'h30, 1'b0, 32'd1);

    // JALR with misaligned target
    stall_FETCH = 1'b1; pcsrc_EX = 2'b01; rs1_data_EX = 32'h103; imm_i_EX = 12'hFFF;
    step();
    check_regs("jalr", 32'h100, 32'h13, 32'h34, 1'b1, 32'd2);
    check("jalr.misalign", {31'd0, misalign}, 32'd1);
    stall_FETCH = 1'b0; pcsrc_EX = 2'b00;
    for (int i = 0; i < 10; i++) step();
    check("jalr.misalign_sticky", {31'd0, misalign}, 32'd1);
    check("jalr.pc_after", pc_F, 32'h128);

    // Reset, then run up to pc_EX=0x40
    rst = 1'b1;
    step();
    check("rst2.misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check_regs("pre_br", 32'h44, 32'h40, 32'h40, 1'b0, 32'd0);

    // Taken branch backwards, request held for a second cycle
    stall_FETCH = 1'b1; pcsrc_EX = 2'b11; imm_b_extended = 32'hFFFF_FFF8;
    step();
    check_regs("br", 32'h38, 32'h13, 32'h44, 1'b1, 32'd1);
    step();
    check_regs("br_hold", 32'h3C, 32'h38, 32'h38, 1'b0, 32'd1);

    // en=0 freezes state despite a pending request
    en = 1'b0; pcsrc_EX = 2'b10; imm_j_extended = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      check_regs($sformatf("frz%0d", i), 32'h3C, 32'h38, 32'h38, 1'b0, 32'd1);
    end
    en = 1'b1;
    step();
    check_regs("unfrz", 32'h138, 32'h13, 32'h3C, 1'b1, 32'd2);
    step();
    check_regs("unfrz_hold", 32'h13C, 32'h138, 32'h138, 1'b0, 32'd2);

    // JAL to the top of the address space, then wrap
    imm_j_extended = 32'hFFFF_FEC4;
    step();
    check_regs("top", 32'hFFFF_FFFC, 32'h13, 32'h13C, 1'b1, 32'd3);
    stall_FETCH = 1'b0; pcsrc_EX = 2'b00;
    step();
    check_regs("wrap", 32'h0, 32'h3FFC, 32'hFFFF_FFFC, 1'b0, 32'd3);
    check("wrap.pc_plus4", pc_plus4_EX, 32'h0);
    check("wrap.misalign", {31'd0, misalign}, 32'd0);
    step();
    check("pre_rst.pc_F", pc_F, 32'h4);

    // Reset coincident with a redirect request
    rst = 1'b1; stall_FETCH = 1'b1; pcsrc_EX = 2'b10; imm_j_extended = 32'h80;
    step();
    check_regs("rst_redir", 32'h0, 32'h13, 32'h0, 1'b1, 32'd0);
    rst = 1'b0; stall_FETCH = 1'b0; pcsrc_EX = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
